// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Flag vectors are ordered {lt, eq, gt}; index them with LT/EQ/GT.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int LT = 2;
  localparam int EQ = 1;
  localparam int GT = 0;

  // Operands must split into a whole number of chunks.
  function automatic bit width_ok(input int width, input int bpc);
    return (width >= 2) && (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/chunk_compare.sv
// Unsigned compare of one BITS_PER_CYCLE-wide chunk of each operand.
// Purely combinational; exactly one of lt/eq/gt is high.
module chunk_compare #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] x,
  input  logic [BITS_PER_CYCLE-1:0] y,
  output logic                      lt,
  output logic                      eq,
  output logic                      gt
);

  assign lt = (x < y);
  assign eq = (x == y);
  assign gt = (x > y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-chunk-first magnitude comparator with early termination.
// Optional two's-complement mode is enabled by defining CMP_SIGNED_EN.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
  input  logic             sign_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!width_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
    $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sh_a, sh_a_nxt;
  logic [WIDTH-1:0]   sh_b, sh_b_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2:0]         flags, flags_nxt;
  logic               done_nxt;
  logic               busy_nxt;
  logic [WIDTH-1:0]   a_ld, b_ld;
  logic               c_lt, c_eq, c_gt;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    a_ld = a;
    b_ld = b;
`ifdef CMP_SIGNED_EN
    if (sign_mode) begin
      a_ld[WIDTH-1] = ~a[WIDTH-1];
      b_ld[WIDTH-1] = ~b[WIDTH-1];
    end
`endif
  end

  chunk_compare #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_chunk (
    .x  (sh_a[WIDTH-1 -: BITS_PER_CYCLE]),
    .y  (sh_b[WIDTH-1 -: BITS_PER_CYCLE]),
    .lt (c_lt),
    .eq (c_eq),
    .gt (c_gt)
  );

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    sh_a_nxt  = sh_a;
    sh_b_nxt  = sh_b;
    cnt_nxt   = cnt;
    flags_nxt = flags;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          sh_a_nxt  = a_ld;
          sh_b_nxt  = b_ld;
          cnt_nxt   = CNT_W'(N - 1);
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!c_eq) begin
          flags_nxt     = '0;
          flags_nxt[LT] = c_lt;
          flags_nxt[GT] = c_gt;
          done_nxt      = 1'b1;
          state_nxt     = IDLE;
        end else if (cnt == '0) begin
          flags_nxt     = '0;
          flags_nxt[EQ] = 1'b1;
          done_nxt      = 1'b1;
          state_nxt     = IDLE;
        end else begin
          sh_a_nxt = sh_a << BITS_PER_CYCLE;
          sh_b_nxt = sh_b << BITS_PER_CYCLE;
          cnt_nxt  = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == RUN);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the operand shift registers are reset too; they are few flops and a known value eases debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      flags <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      sh_a  <= sh_a_nxt;
      sh_b  <= sh_b_nxt;
      cnt   <= cnt_nxt;
      flags <= flags_nxt;
      done  <= done_nxt;
      busy  <= busy_nxt;
    end
  end

  assign lt = flags[LT];
  assign eq = flags[EQ];
  assign gt = flags[GT];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench: two comparator instances (1 and 4 bits per cycle),
// table-driven vectors plus hand sequences, checked through a scoreboard.
module tb_seq_magnitude_comparator;

  typedef struct {
    int         unit;
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic [2:0] flags;   // {lt, eq, gt}
    int         lat;
  } vec_t;

  typedef struct {
    logic [2:0] flags;
    int         lat;
    int         acc;
  } exp_t;

  localparam logic [2:0] F_LT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_GT = 3'b001;

  logic       clk;
  logic       rst_n;
  logic       s1, s4;
  logic [7:0] a1, b1, a4, b4;
  logic       busy1, done1, lt1, eq1, gt1;
  logic       busy4, done4, lt4, eq4, gt4;
`ifdef CMP_SIGNED_EN
  logic       sm1, sm4;
`endif

  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t q1[$];
  exp_t q4[$];
  vec_t tbl[$];

  seq_magnitude_comparator #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (s1),
    .a         (a1),
    .b         (b1),
`ifdef CMP_SIGNED_EN
    .sign_mode (sm1),
`endif
    .busy      (busy1),
    .done      (done1),
    .lt        (lt1),
    .eq        (eq1),
    .gt        (gt1)
  );

  seq_magnitude_comparator #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (s4),
    .a         (a4),
    .b         (b4),
`ifdef CMP_SIGNED_EN
    .sign_mode (sm4),
`endif
    .busy      (busy4),
    .done      (done4),
    .lt        (lt4),
    .eq        (eq4),
    .gt        (gt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int u, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s unit%0d @cyc %0d: got %0h, want %0h", name, u, cyc, act, exp);
    end
  endtask

  // Called at a falling edge; start is held across the next rising edge.
  task automatic issue(input int u, input logic [7:0] va, input logic [7:0] vb,
                       input logic vsm, input logic [2:0] ef, input int el);
    exp_t e;
    e.flags = ef;
    e.lat   = el;
    e.acc   = cyc + 1;
    if (u == 1) begin
      a1 = va; b1 = vb; s1 = 1'b1;
`ifdef CMP_SIGNED_EN
      sm1 = vsm;
`endif
      q1.push_back(e);
    end else begin
      a4 = va; b4 = vb; s4 = 1'b1;
`ifdef CMP_SIGNED_EN
      sm4 = vsm;
`endif
      q4.push_back(e);
    end
    @(negedge clk);
    s1 = 1'b0;
    s4 = 1'b0;
  endtask

  task automatic wait_done(input int u);
    int left;
    left = (u == 1) ? q1.size() : q4.size();
    for (int k = 0; k < 40 && left != 0; k++) begin
      @(negedge clk);
      left = (u == 1) ? q1.size() : q4.size();
    end
    check("done_seen", u, int'(left == 0), 1);
    if (u == 1) q1.delete(); else q4.delete();
  endtask

  task automatic mon(input int u, input logic d, input logic bsy, input logic [2:0] f);
    exp_t e;
    logic have;
    have = (u == 1) ? (q1.size() > 0) : (q4.size() > 0);
    if (have) e = (u == 1) ? q1[0] : q4[0];
    if (d) begin
      if (!have) begin
        check("unexpected_done", u, 1, 0);
      end else begin
        if (u == 1) q1.delete(0); else q4.delete(0);
        check("flags", u, int'(f), int'(e.flags));
        check("latency", u, cyc - e.acc, e.lat);
        check("busy_in_done", u, int'(bsy), 0);
      end
    end else if (have && cyc >= e.acc) begin
      check("busy_while_run", u, int'(bsy), 1);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(1, done1, busy1, {lt1, eq1, gt1});
      mon(4, done4, busy4, {lt4, eq4, gt4});
    end
  end

  initial begin
    vec_t v;
    bit   seen;

    rst_n = 1'b0;
    s1 = 1'b0; a1 = '0; b1 = '0;
    s4 = 1'b0; a4 = '0; b4 = '0;
`ifdef CMP_SIGNED_EN
    sm1 = 1'b0; sm4 = 1'b0;
`endif

    tbl.push_back('{1, 8'h80, 8'h7F, 1'b0, F_GT, 1});
    tbl.push_back('{1, 8'h5A, 8'h5A, 1'b0, F_EQ, 8});
    tbl.push_back('{1, 8'h00, 8'h01, 1'b0, F_LT, 8});
    tbl.push_back('{1, 8'hFF, 8'hFE, 1'b0, F_GT, 8});
    tbl.push_back('{1, 8'h12, 8'h32, 1'b0, F_LT, 3});
    tbl.push_back('{1, 8'h00, 8'h00, 1'b0, F_EQ, 8});
    tbl.push_back('{1, 8'h40, 8'h00, 1'b0, F_GT, 2});
    tbl.push_back('{4, 8'h35, 8'h3A, 1'b0, F_LT, 2});
    tbl.push_back('{4, 8'hA0, 8'h5F, 1'b0, F_GT, 1});
    tbl.push_back('{4, 8'hC3, 8'hC3, 1'b0, F_EQ, 2});
    tbl.push_back('{4, 8'h0F, 8'hF0, 1'b0, F_LT, 1});
`ifdef CMP_SIGNED_EN
    tbl.push_back('{1, 8'h80, 8'h01, 1'b1, F_LT, 1});
    tbl.push_back('{1, 8'h80, 8'h01, 1'b0, F_GT, 1});
    tbl.push_back('{4, 8'hFF, 8'h01, 1'b1, F_LT, 1});
    tbl.push_back('{1, 8'hFE, 8'hFF, 1'b1, F_LT, 8});
`endif

    repeat (2) @(negedge clk);
    check("reset_outs", 1, int'({busy1, done1, lt1, eq1, gt1}), 0);
    check("reset_outs", 4, int'({busy4, done4, lt4, eq4, gt4}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      v = tbl[i];
      issue(v.unit, v.a, v.b, v.sm, v.flags, v.lat);
      wait_done(v.unit);
    end

    // Idle after a 1-cycle result: busy stays low and flags are held.
    issue(1, 8'h80, 8'h7F, 1'b0, F_GT, 1);
    wait_done(1);
    repeat (4) @(negedge clk);
    check("idle_busy", 1, int'(busy1), 0);
    check("held_flags", 1, int'({lt1, eq1, gt1}), int'(F_GT));

    // Back-to-back: second start lands in the done cycle of the first.
    issue(4, 8'h35, 8'h3A, 1'b0, F_LT, 2);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (done4) seen = 1'b1;
      else @(negedge clk);
    end
    check("b2b_first_done", 4, int'(seen), 1);
    issue(4, 8'h3A, 8'h35, 1'b0, F_GT, 2);
    wait_done(4);

    // start during RUN is ignored and not queued.
    issue(1, 8'h5A, 8'h5A, 1'b0, F_EQ, 8);
    @(negedge clk);
    a1 = 8'h00; b1 = 8'hFF; s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    wait_done(1);
    repeat (12) @(negedge clk);
    check("ignored_start_flags", 1, int'({lt1, eq1, gt1}), int'(F_EQ));
    check("ignored_start_busy", 1, int'(busy1), 0);

    // Reset mid-run aborts: no done, all flags cleared.
    issue(1, 8'h5A, 8'h5A, 1'b0, F_EQ, 8);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", 1, int'({busy1, done1, lt1, eq1, gt1}), 0);
    check("midrst_outs", 4, int'({busy4, done4, lt4, eq4, gt4}), 0);
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_outs", 1, int'({busy1, done1, lt1, eq1, gt1}), 0);
    issue(1, 8'h12, 8'h32, 1'b0, F_LT, 3);
    wait_done(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
